parallel_fir_ctrl: RTL and testbench

Stream controller for the 4-lane parallel FIR datapath. Packs a serial valid/ready sample stream into 4-sample blocks and drives the datapath's lane inputs and enable. Tracks which datapath outputs are valid, then serializes the 4 filtered outputs back onto a valid/ready stream. Provides an end-of-stream flush that zero-pads a partial block and drains the pipeline.

---
 rtl/parallel_fir_ctrl_pkg.sv | 13 +
 rtl/parallel_fir_ctrl_serializer.sv | 48 ++++
 rtl/parallel_fir_ctrl.sv | 152 +++++++++++++++
 tb/tb_parallel_fir_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_fir_ctrl_pkg.sv
// Shared definitions for the parallel FIR stream controller: lane count and
// controller state encoding.
package parallel_fir_ctrl_pkg;

    localparam int N_PARAL = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/parallel_fir_ctrl_serializer.sv
// Output side of the FIR controller: holds one captured block of datapath
// results and plays it out lane 0..3 on a valid/ready stream.
module fir_out_serializer
    import parallel_fir_ctrl_pkg::*;
#(
    parameter int NB_DATA_OUT = 19
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   load,
    input  logic [NB_DATA_OUT-1:0] lane_data [N_PARAL],
    input  logic                   ready,
    output logic [NB_DATA_OUT-1:0] sample,
    output logic                   valid,
    output logic                   empty
);

    logic [NB_DATA_OUT-1:0] out_buf [N_PARAL];
    logic [1:0]             rd_idx;
    logic                   full;

    // A load only ever lands on an empty buffer, so it never races a read.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N_PARAL; i++) begin
                out_buf[i] <= '0;
            end
            rd_idx <= '0;
            full   <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < N_PARAL; i++) begin
                out_buf[i] <= lane_data[i];
            end
            rd_idx <= '0;
            full   <= 1'b1;
        end else if (full && ready) begin
            rd_idx <= rd_idx + 2'd1;
            if (rd_idx == 2'(N_PARAL - 1)) begin
                full <= 1'b0;
            end
        end
    end

    assign sample = out_buf[rd_idx];
    assign valid  = full;
    assign empty  = !full;

endmodule

// File: rtl/parallel_fir_ctrl.sv
// Stream controller for the 4-lane parallel FIR: packs serial samples into
// blocks, tracks datapath validity, serializes results and handles flush.
module parallel_fir_ctrl
    import parallel_fir_ctrl_pkg::*;
#(
    parameter int NB_DATA_IN  = 8,
    parameter int NB_DATA_OUT = 19,
    parameter int PIPE_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic signed [NB_DATA_IN-1:0]  i_sample,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_flush,
    output logic signed [NB_DATA_IN-1:0]  o_fir_data_0,
    output logic signed [NB_DATA_IN-1:0]  o_fir_data_1,
    output logic signed [NB_DATA_IN-1:0]  o_fir_data_2,
    output logic signed [NB_DATA_IN-1:0]  o_fir_data_3,
    output logic                          o_fir_en,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_data_0,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_data_1,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_data_2,
    input  logic signed [NB_DATA_OUT-1:0] i_fir_data_3,
    output logic signed [NB_DATA_OUT-1:0] o_sample,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy
);

    state_t                 state, state_next;
    logic [1:0]             cnt, cnt_base, cnt_next;
    logic                   pack_full, pack_full_next;
    logic [NB_DATA_IN-1:0]  pack [N_PARAL];
    logic [PIPE_LAT-1:0]    vld_sr, vld_sr_shift, vld_sr_next;
    logic                   cap_pend, rst_done;
    logic                   accept, issue, issue_req, tag;
    logic                   pend, pend_next, buf_empty, go_pad;
    logic [NB_DATA_OUT-1:0] fir_out [N_PARAL];

    // "pend" means a tagged block is still inside the datapath and needs more
    // enables to reach the outputs; the top bit has already been captured.
    if (PIPE_LAT > 1) begin : g_pend
        assign pend         = |vld_sr[PIPE_LAT-2:0];
        assign pend_next    = |vld_sr_next[PIPE_LAT-2:0];
        assign vld_sr_shift = {vld_sr[PIPE_LAT-2:0], tag};
    end else begin : g_no_pend
        assign pend         = 1'b0;
        assign pend_next    = 1'b0;
        assign vld_sr_shift = tag;
    end

    assign tag            = pack_full;
    assign issue_req      = pack_full || (state == ST_DRAIN && pend);
    assign issue          = issue_req && buf_empty && !cap_pend;
    assign accept         = i_valid && o_ready;
    assign cnt_base       = issue ? 2'd0 : cnt;
    assign cnt_next       = cnt_base + {1'b0, accept};
    assign pack_full_next = (accept && cnt_base == 2'd3) || (pack_full && !issue);
    assign vld_sr_next    = issue ? vld_sr_shift : vld_sr;
    assign go_pad         = state == ST_RUN && i_flush && !pack_full_next && cnt_next != 2'd0;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Flush is judged on the post-accept view so a same-cycle sample counts.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (go_pad) begin
                    state_next = ST_PAD;
                end else if (i_flush && (pack_full_next || pend_next)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_PAD: begin
                if (issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pack_full && !pend && !cap_pend && buf_empty) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        o_busy   = state != ST_RUN;
        o_fir_en = issue;
        o_ready  = rst_done && state == ST_RUN && (!pack_full || issue);
    end

    // Lanes are zeroed on every issue, so padding and bubbles see zero data.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt       <= '0;
            pack_full <= 1'b0;
            vld_sr    <= '0;
            cap_pend  <= 1'b0;
            rst_done  <= 1'b0;
            for (int i = 0; i < N_PARAL; i++) begin
                pack[i] <= '0;
            end
        end else begin
            rst_done  <= 1'b1;
            cnt       <= cnt_next;
            pack_full <= pack_full_next || go_pad;
            vld_sr    <= vld_sr_next;
            cap_pend  <= issue && vld_sr_shift[PIPE_LAT-1];
            for (int i = 0; i < N_PARAL; i++) begin
                if (accept && cnt_base == 2'(i)) begin
                    pack[i] <= i_sample;
                end else if (issue) begin
                    pack[i] <= '0;
                end
            end
        end
    end

    assign o_fir_data_0 = pack[0];
    assign o_fir_data_1 = pack[1];
    assign o_fir_data_2 = pack[2];
    assign o_fir_data_3 = pack[3];

    assign fir_out[0] = i_fir_data_0;
    assign fir_out[1] = i_fir_data_1;
    assign fir_out[2] = i_fir_data_2;
    assign fir_out[3] = i_fir_data_3;

    fir_out_serializer #(
        .NB_DATA_OUT(NB_DATA_OUT)
    ) u_serializer (
        .clk       (clk),
        .i_rst     (i_rst),
        .load      (cap_pend),
        .lane_data (fir_out),
        .ready     (i_ready),
        .sample    (o_sample),
        .valid     (o_valid),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_parallel_fir_ctrl.sv
// Randomized bench for parallel_fir_ctrl: an identity datapath model plus a
// stream-level scoreboard of expected blocks and output samples.
module tb_parallel_fir_ctrl;

    localparam int NB_IN    = 8;
    localparam int NB_OUT   = 19;
    localparam int PIPE_LAT = 2;
    localparam int N        = 4;
    localparam int LATENCY  = 2 + 4 * (PIPE_LAT - 1) + 1;

    logic                     clk = 1'b0;
    logic                     i_rst;
    logic signed [NB_IN-1:0]  i_sample;
    logic                     i_valid, o_ready, i_flush, o_fir_en;
    logic signed [NB_IN-1:0]  o_fir_data_0, o_fir_data_1, o_fir_data_2, o_fir_data_3;
    logic signed [NB_OUT-1:0] i_fir_data_0, i_fir_data_1, i_fir_data_2, i_fir_data_3;
    logic signed [NB_OUT-1:0] o_sample;
    logic                     o_valid, i_ready, o_busy;

    always #5 clk = ~clk;

    parallel_fir_ctrl #(
        .NB_DATA_IN (NB_IN),
        .NB_DATA_OUT(NB_OUT),
        .PIPE_LAT   (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_sample    (i_sample),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_flush     (i_flush),
        .o_fir_data_0(o_fir_data_0),
        .o_fir_data_1(o_fir_data_1),
        .o_fir_data_2(o_fir_data_2),
        .o_fir_data_3(o_fir_data_3),
        .o_fir_en    (o_fir_en),
        .i_fir_data_0(i_fir_data_0),
        .i_fir_data_1(i_fir_data_1),
        .i_fir_data_2(i_fir_data_2),
        .i_fir_data_3(i_fir_data_3),
        .o_sample    (o_sample),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy)
    );

    // Datapath stand-in: PIPE_LAT enable-advanced stages, identity per lane.
    logic [NB_IN-1:0] lanes [N];
    logic [NB_IN-1:0] dp [PIPE_LAT][N];

    assign lanes[0] = o_fir_data_0;
    assign lanes[1] = o_fir_data_1;
    assign lanes[2] = o_fir_data_2;
    assign lanes[3] = o_fir_data_3;

    always @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int s = 0; s < PIPE_LAT; s++)
                for (int k = 0; k < N; k++) dp[s][k] <= '0;
        end else if (o_fir_en) begin
            for (int k = 0; k < N; k++) dp[0][k] <= lanes[k];
            for (int s = 1; s < PIPE_LAT; s++)
                for (int k = 0; k < N; k++) dp[s][k] <= dp[s-1][k];
        end
    end

    function automatic logic [NB_OUT-1:0] sext(input logic [NB_IN-1:0] v);
        return {{(NB_OUT - NB_IN){v[NB_IN-1]}}, v};
    endfunction

    assign i_fir_data_0 = sext(dp[PIPE_LAT-1][0]);
    assign i_fir_data_1 = sext(dp[PIPE_LAT-1][1]);
    assign i_fir_data_2 = sext(dp[PIPE_LAT-1][2]);
    assign i_fir_data_3 = sext(dp[PIPE_LAT-1][3]);

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [NB_OUT-1:0] exp_out [$];
    logic [NB_IN-1:0]  blk_q [$];
    logic [NB_IN-1:0]  src_q [$];
    logic [NB_IN-1:0]  cur [N];
    logic [NB_IN-1:0]  first_blk [N];
    int  in_cnt = 0;
    int  valid_pct = 100, ready_pct = 100, ready_hold = 0;
    bit  flush_now = 0, flush_with_last = 0, bp_arm = 0, capture_first = 0;
    int  fir_en_cnt = 0, bubble_cnt = 0, accept_cnt = 0, out_cnt = 0;
    int  first_valid_cycle = -1, fourth_cycle = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_block();
        for (int k = 0; k < N; k++) begin
            blk_q.push_back(cur[k]);
            exp_out.push_back(sext(cur[k]));
        end
        in_cnt = 0;
    endtask

    task automatic apply_stimulus();
        i_flush = 1'b0;
        if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            i_valid  = 1'b1;
            i_sample = src_q[0];
        end else begin
            i_valid  = 1'b0;
            i_sample = NB_IN'($urandom);
        end
        if (flush_now) begin
            i_flush   = 1'b1;
            flush_now = 0;
        end
        if (flush_with_last && i_valid && src_q.size() == 1) begin
            i_flush         = 1'b1;
            flush_with_last = 0;
        end
        if (bp_arm && o_valid) begin
            ready_hold = 10;
            bp_arm     = 0;
        end
        if (ready_hold > 0) begin
            i_ready = 1'b0;
            ready_hold--;
        end else begin
            i_ready = ($urandom_range(99) < ready_pct);
        end
    endtask

    // Called at the falling edge: scores what the coming rising edge will do.
    task automatic check_output();
        if (o_fir_en) begin
            fir_en_cnt++;
            check("fir_en_while_output_busy", {31'd0, o_valid}, 32'd0);
            if (capture_first) begin
                for (int k = 0; k < N; k++) first_blk[k] = lanes[k];
                capture_first = 0;
            end
            if (blk_q.size() >= N) begin
                for (int k = 0; k < N; k++)
                    check($sformatf("lane%0d", k), {24'd0, lanes[k]}, {24'd0, blk_q.pop_front()});
            end else begin
                bubble_cnt++;
                for (int k = 0; k < N; k++)
                    check($sformatf("bubble_lane%0d", k), {24'd0, lanes[k]}, 32'd0);
            end
        end
        if (i_valid && o_ready) begin
            accept_cnt++;
            cur[in_cnt] = i_sample;
            in_cnt++;
            void'(src_q.pop_front());
            if (in_cnt == N) begin
                if (accept_cnt == N && fourth_cycle < 0) fourth_cycle = cycle;
                push_block();
            end
        end
        if (i_flush && in_cnt > 0) begin
            for (int k = in_cnt; k < N; k++) cur[k] = '0;
            push_block();
        end
        if (o_valid) begin
            if (first_valid_cycle < 0) first_valid_cycle = cycle;
            if (exp_out.size() == 0) begin
                check("spurious_o_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                check("o_sample", {13'd0, o_sample}, {13'd0, exp_out[0]});
                if (i_ready) begin
                    void'(exp_out.pop_front());
                    out_cnt++;
                end
            end
        end
    endtask

    task automatic step();
        apply_stimulus();
        @(negedge clk);
        if (i_rst) check_output();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send_all(input string name);
        int n = 0;
        while (src_q.size() > 0 && n < 5000) begin
            step();
            n++;
        end
        check({name, "_input_accepted"}, src_q.size(), 32'd0);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((o_busy || exp_out.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        check({name, "_drained"}, {31'd0, (exp_out.size() == 0 && !o_busy)}, 32'd1);
    endtask

    initial begin
        int n;
        i_rst    = 1'b0;
        i_valid  = 1'b1;
        i_sample = 8'h55;
        i_flush  = 1'b0;
        i_ready  = 1'b1;

        // Reset held with a valid sample on the input.
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_ready", {31'd0, o_ready}, 32'd0);
        check("reset_o_fir_en", {31'd0, o_fir_en}, 32'd0);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check("reset_o_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b1;
        i_valid = 1'b0;
        step();
        check("ready_after_release", {31'd0, o_ready}, 32'd1);

        // Flush with nothing pending is ignored.
        fir_en_cnt = 0;
        flush_now = 1;
        step();
        check("busy_empty_flush", {31'd0, o_busy}, 32'd0);
        repeat (5) step();
        check("fir_en_empty_flush", fir_en_cnt, 32'd0);

        // Continuous stream 1..16.
        accept_cnt = 0; out_cnt = 0; capture_first = 1;
        first_valid_cycle = -1; fourth_cycle = -1;
        for (int v = 1; v <= 16; v++) src_q.push_back(NB_IN'(v));
        send_all("stream");
        flush_now = 1;
        wait_drained("stream");
        check("first_block_lane0", {24'd0, first_blk[0]}, 32'd1);
        check("first_block_lane3", {24'd0, first_blk[3]}, 32'd4);
        check("first_valid_latency", first_valid_cycle - fourth_cycle, LATENCY);
        check("stream_out_count", out_cnt, 32'd16);

        // Backpressure: ready low for 10 cycles once output starts.
        out_cnt = 0;
        for (int v = 0; v < 16; v++) src_q.push_back(NB_IN'($urandom));
        bp_arm = 1;
        send_all("backpressure");
        flush_now = 1;
        wait_drained("backpressure");
        check("backpressure_out_count", out_cnt, 32'd16);

        // Random traffic with a partial tail.
        out_cnt = 0; valid_pct = 70; ready_pct = 60;
        n = 150;
        for (int v = 0; v < n; v++) src_q.push_back(NB_IN'($urandom));
        send_all("random");
        flush_now = 1;
        wait_drained("random");
        check("random_out_count", out_cnt, ((n + N - 1) / N) * N);
        valid_pct = 100; ready_pct = 100;

        // Flush of a partial block 5,6.
        out_cnt = 0;
        src_q.push_back(8'd5);
        src_q.push_back(8'd6);
        send_all("pad");
        fir_en_cnt = 0; bubble_cnt = 0; capture_first = 1;
        flush_now = 1;
        step();
        check("busy_after_pad_flush", {31'd0, o_busy}, 32'd1);
        wait_drained("pad");
        check("pad_lane0", {24'd0, first_blk[0]}, 32'd5);
        check("pad_lane1", {24'd0, first_blk[1]}, 32'd6);
        check("pad_lane2", {24'd0, first_blk[2]}, 32'd0);
        check("pad_lane3", {24'd0, first_blk[3]}, 32'd0);
        check("pad_bubbles", bubble_cnt, PIPE_LAT - 1);
        check("pad_fir_en_count", fir_en_cnt, PIPE_LAT);
        check("pad_out_count", out_cnt, 32'd4);

        // Flush together with the 4th accept.
        out_cnt = 0; fir_en_cnt = 0; bubble_cnt = 0;
        for (int v = 21; v <= 24; v++) src_q.push_back(NB_IN'(v));
        flush_with_last = 1;
        send_all("flush4");
        check("busy_after_flush4", {31'd0, o_busy}, 32'd1);
        wait_drained("flush4");
        check("flush4_out_count", out_cnt, 32'd4);
        check("flush4_bubbles", bubble_cnt, PIPE_LAT - 1);

        // Asynchronous reset in the middle of a drain.
        for (int v = 7; v <= 9; v++) src_q.push_back(NB_IN'(v));
        send_all("mid_reset");
        flush_now = 1;
        step();
        step();
        check("busy_before_reset", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b0;
        #1;
        check("async_o_busy", {31'd0, o_busy}, 32'd0);
        check("async_o_valid", {31'd0, o_valid}, 32'd0);
        check("async_o_fir_en", {31'd0, o_fir_en}, 32'd0);
        check("async_o_ready", {31'd0, o_ready}, 32'd0);
        check("async_o_sample", {13'd0, o_sample}, 32'd0);
        check("async_lane0", {24'd0, o_fir_data_0}, 32'd0);
        exp_out.delete();
        blk_q.delete();
        in_cnt = 0;
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        step();
        out_cnt = 0; capture_first = 1;
        for (int v = 31; v <= 34; v++) src_q.push_back(NB_IN'(v));
        send_all("after_reset");
        flush_now = 1;
        wait_drained("after_reset");
        check("after_reset_lane0", {24'd0, first_blk[0]}, 32'd31);
        check("after_reset_lane3", {24'd0, first_blk[3]}, 32'd34);
        check("after_reset_out_count", out_cnt, 32'd4);

        repeat (4) step();
        check("final_blocks_left", blk_q.size(), 32'd0);
        check("final_o_valid", {31'd0, o_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
